mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Single-port memory arbiter/sequencer between the instruction-fetch path and the load/store path of the RV32I core.
- Owns the shared sram control signals: address, byte-lane mask, active-low write strobe and write-data drive enable.
- Sequences each access as a short FSM: read, write-strobe, bus recovery.
- Replaces ad-hoc microop-based bus steering in the core; the core only raises requests and consumes valid pulses.

Parameters:
- AW, 32, address width.
- DW, 32, data width (fixed at 32 for the current sram).
- WR_CYCLES, 1, cycles mem_rwr is held low per write (1..4).

Ports:
- clk  input  1  rising-edge clock.
- rts  input  1  reset, synchronous, active-low.
- if_req  input  1  fetch request; held until if_valid.
- if_addr  input  AW  fetch address.
- if_gnt  output  1  fetch accepted this cycle.
- if_valid  output  1  one-cycle pulse; if_rdata valid.
- if_rdata  output  DW  fetched word.
- ls_req  input  1  load/store request; held until ls_valid.
- ls_we  input  1  1 = store, 0 = load.
- ls_size  input  2  0 = byte, 1 = half, 2/3 = word.
- ls_addr  input  AW  data address.
- ls_wdata  input  DW  store data.
- ls_gnt  output  1  load/store accepted this cycle.
- ls_valid  output  1  one-cycle pulse; load data valid or store complete.
- ls_rdata  output  DW  loaded word (raw, unextended).
- mem_addr  output  AW  sram address.
- mem_dsize  output  4  sram byte-lane mask.
- mem_rwr  output  1  sram write strobe, active-low.
- mem_wdata  output  DW  sram write data.
- mem_wdata_oe  output  1  drive enable for shared data bus.
- mem_rdata  input  DW  sram read data.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset, sampled at the clk edge with rts = 0: state IDLE; mem_rwr = 1; mem_wdata_oe = 0; mem_dsize = 0; mem_addr = 0; all gnt/valid = 0; rdata regs = 0; round-robin pointer = fetch.
- States: IDLE, READ, WRITE, RECOVER.
- Grant rules:
  - if_gnt and ls_gnt are combinational and only possible in IDLE.
  - At most one gnt per cycle.
  - On the granting edge, the arbiter latches address, we, size and wdata.
- Arbitration: fixed priority, ls over if.
  - Whichever request is not granted stays pending with no state change.
- Size to mask:
  - Fetch: always 4'b1111.
  - ls_size 0 gives 0001, 1 gives 0011, 2 and 3 give 1111.
- No alignment check; mem_addr equals the latched address unchanged.
- Read (fetch, or load):
  - Transitions IDLE -> READ -> IDLE.
  - In READ: mem_addr and mem_dsize driven, mem_rwr = 1, mem_wdata_oe = 0.
  - mem_rdata is captured at the end of READ.
  - The matching valid pulses in the next cycle (back in IDLE) with rdata held until the next capture.
  - Latency from gnt cycle to valid = 2 cycles; a new grant may occur in the valid cycle.
- Store:
  - Transitions IDLE -> WRITE (WR_CYCLES cycles) -> RECOVER -> IDLE.
  - In WRITE: mem_rwr = 0, mem_wdata_oe = 1, address, mask and data stable.
  - In RECOVER: mem_rwr = 1, mem_wdata_oe = 1, address held, so data stays driven past the strobe's rising edge.
  - ls_valid pulses in the cycle after RECOVER; gnt to valid = WR_CYCLES + 2.
- Outside READ/WRITE/RECOVER: mem_dsize = 0, mem_rwr = 1, mem_wdata_oe = 0.
- Requester drops req before its gnt: legal, nothing issued.
- Requester drops req after gnt: the access completes and valid still pulses.
- Reset mid-operation (any state): IDLE on the next edge; mem_rwr = 1 at that edge; no valid pulse for the aborted access.
- Write-strobe counter wraps from WR_CYCLES-1 only to RECOVER, never back to WRITE.
- busy = 1 exactly in READ, WRITE and RECOVER.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous requests, grant the requester not granted last.
  - Pointer updates on each grant; reset pointer favours ls first (pointer = fetch means fetch was last).
- MEM_ARB_RR_EN undefined: fixed ls-over-if priority; no pointer register.

Test Plan:
- Reset, then if_req with if_addr = 0x00000010 and mem_rdata = 0x00A00093 -> if_gnt in cycle 0, READ in cycle 1 with mem_dsize = 1111, if_valid pulse in cycle 2 with if_rdata = 0x00A00093.
- Store with ls_size = 0, ls_addr = 0x103, ls_wdata = 0xDEADBEEF, WR_CYCLES = 2 -> mem_rwr low exactly 2 cycles, mem_dsize = 0001, mem_wdata_oe high 3 cycles, ls_valid 4 cycles after gnt.
- if_req and ls_req in the same cycle, macro off -> ls granted first; if granted in the ls_valid cycle (load) or after store RECOVER.
- MEM_ARB_RR_EN on, both requesting continuously for 4 grants -> grant order ls, if, ls, if.
- rts = 0 asserted during WRITE -> mem_rwr = 1 and mem_wdata_oe = 0 at that edge, no ls_valid, IDLE after rts release.
- ls_req withdrawn while if owns the bus -> no ls_gnt, no memory activity after if_valid, busy = 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and sram signal bundle for mem_port_arbiter
// slave modport is the arbiter side; master modport is the core plus sram side
// if_*: fetch request/grant/valid/data; ls_*: load/store request/grant/valid/data
// mem_*: shared sram address, byte-lane mask, active-low strobe, write data and drive enable
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [1:0]    ls_size;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_valid;
  logic [DW-1:0] ls_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_dsize;
  logic          mem_rwr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wdata_oe;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
    output mem_addr, mem_dsize, mem_rwr, mem_wdata, mem_wdata_oe
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
    input  mem_addr, mem_dsize, mem_rwr, mem_wdata, mem_wdata_oe
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port sram arbiter/sequencer between fetch and load/store paths
// ports: clk, rts (sync active-low reset), bus (mem_port_arbiter_if.slave), busy (FSM not IDLE)
// MEM_ARB_RR_EN defined: round-robin between simultaneous requests; undefined: ls over if
// reads take IDLE->READ->IDLE, stores IDLE->WRITE(WR_CYCLES)->RECOVER->IDLE
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int WR_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rts,
  mem_port_arbiter_if.slave      bus,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic [3:0]    dsize_q, dsize_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          rwr_q, rwr_d, oe_q, oe_d, own_ls_q, own_ls_d;
  logic          if_valid_q, if_valid_d, ls_valid_q, ls_valid_d;
  logic          idle, if_gnt, ls_gnt;
  logic [3:0]    ls_mask;
  assign idle    = state_q == IDLE && rts;
  assign ls_mask = bus.ls_size == 2'd0 ? 4'b0001 : bus.ls_size == 2'd1 ? 4'b0011 : 4'b1111;
`ifdef MEM_ARB_RR_EN
  // last_ls_q = 1 means ls got the most recent grant, so fetch wins the next tie
  logic last_ls_q, last_ls_d;
  assign ls_gnt    = idle && bus.ls_req && !(bus.if_req && last_ls_q);
  assign last_ls_d = ls_gnt ? 1'b1 : if_gnt ? 1'b0 : last_ls_q;
  always_ff @(posedge clk)
    last_ls_q <= !rts ? 1'b0 : last_ls_d;
`else
  assign ls_gnt = idle && bus.ls_req;
`endif
  assign if_gnt = idle && bus.if_req && !ls_gnt;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dsize_d    = dsize_q;
    cnt_d      = cnt_q;
    rwr_d      = rwr_q;
    oe_d       = oe_q;
    own_ls_d   = own_ls_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_valid_d = 1'b0;
    ls_valid_d = 1'b0;
    case (state_q)
      IDLE: if (ls_gnt || if_gnt) begin
        own_ls_d = ls_gnt;
        addr_d   = ls_gnt ? bus.ls_addr : bus.if_addr;
        dsize_d  = ls_gnt ? ls_mask : 4'b1111;
        wdata_d  = bus.ls_wdata;
        cnt_d    = 2'd0;
        state_d  = ls_gnt && bus.ls_we ? WRITE : READ;
        rwr_d    = !(ls_gnt && bus.ls_we);
        oe_d     = ls_gnt && bus.ls_we;
      end
      READ: begin
        state_d    = IDLE;
        dsize_d    = 4'b0000;
        ls_rdata_d = own_ls_q ? bus.mem_rdata : ls_rdata_q;
        if_rdata_d = own_ls_q ? if_rdata_q : bus.mem_rdata;
        ls_valid_d = own_ls_q;
        if_valid_d = !own_ls_q;
      end
      WRITE: if (cnt_q == 2'(WR_CYCLES - 1)) begin
        state_d = RECOVER;
        rwr_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
      RECOVER: begin
        state_d    = IDLE;
        oe_d       = 1'b0;
        dsize_d    = 4'b0000;
        ls_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rts) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      dsize_q    <= 4'b0000;
      cnt_q      <= 2'd0;
      rwr_q      <= 1'b1;
      oe_q       <= 1'b0;
      own_ls_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dsize_q    <= dsize_d;
      cnt_q      <= cnt_d;
      rwr_q      <= rwr_d;
      oe_q       <= oe_d;
      own_ls_q   <= own_ls_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_valid_q <= if_valid_d;
      ls_valid_q <= ls_valid_d;
    end
  end
  assign bus.if_gnt       = if_gnt;
  assign bus.ls_gnt       = ls_gnt;
  assign bus.if_valid     = if_valid_q;
  assign bus.ls_valid     = ls_valid_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.ls_rdata     = ls_rdata_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_dsize    = dsize_q;
  assign bus.mem_rwr      = rwr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_wdata_oe = oe_q;
  assign busy             = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with WR_CYCLES = 2
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rts = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] rwr_e   = 4'b1100;
  logic [3:0] oe_e    = 4'b0111;
  logic [3:0] valid_e = 4'b1000;
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter #(.AW(32), .DW(32), .WR_CYCLES(2)) dut (
    .clk  (clk),
    .rts  (rts),
    .bus  (bus),
    .busy (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = 0;
    bus.ls_addr = 0; bus.ls_wdata = 0; bus.mem_rdata = 0;
    tick();
    tick();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rwr", bus.mem_rwr, 1);
    chk("rst_oe", bus.mem_wdata_oe, 0);
    chk("rst_dsize", bus.mem_dsize, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_ifv", bus.if_valid, 0);
    chk("rst_lsv", bus.ls_valid, 0);
    chk("rst_ifd", bus.if_rdata, 0);
    chk("rst_lsd", bus.ls_rdata, 0);
    rts = 1;
    // fetch
    tick();
    bus.if_req = 1; bus.if_addr = 32'h10; bus.mem_rdata = 32'h00A00093;
    #1;
    chk("f_ifgnt", bus.if_gnt, 1);
    chk("f_lsgnt", bus.ls_gnt, 0);
    tick(); #1;
    chk("f_busy", busy, 1);
    chk("f_dsize", bus.mem_dsize, 4'hF);
    chk("f_addr", bus.mem_addr, 32'h10);
    chk("f_rwr", bus.mem_rwr, 1);
    chk("f_oe", bus.mem_wdata_oe, 0);
    chk("f_early", bus.if_valid, 0);
    tick();
    bus.if_req = 0;
    #1;
    chk("f_valid", bus.if_valid, 1);
    chk("f_rdata", bus.if_rdata, 32'h00A00093);
    chk("f_idle", busy, 0);
    tick(); #1;
    chk("f_pulse", bus.if_valid, 0);
    // byte store
    tick();
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_size = 0; bus.ls_addr = 32'h103; bus.ls_wdata = 32'hDEADBEEF;
    #1;
    chk("s_gnt", bus.ls_gnt, 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) bus.ls_req = 0;
      #1;
      chk($sformatf("s_rwr%0d", c), bus.mem_rwr, rwr_e[c-1]);
      chk($sformatf("s_oe%0d", c), bus.mem_wdata_oe, oe_e[c-1]);
      chk($sformatf("s_valid%0d", c), bus.ls_valid, valid_e[c-1]);
      chk($sformatf("s_dsize%0d", c), bus.mem_dsize, c <= 3 ? 4'b0001 : 4'b0000);
      if (c == 1) begin
        chk("s_addr", bus.mem_addr, 32'h103);
        chk("s_wdata", bus.mem_wdata, 32'hDEADBEEF);
      end
    end
`ifndef MEM_ARB_RR_EN
    // simultaneous load and fetch, ls wins
    tick();
    bus.if_req = 1; bus.if_addr = 32'h20;
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = 1; bus.ls_addr = 32'h40; bus.mem_rdata = 32'h11223344;
    #1;
    chk("p_lsgnt", bus.ls_gnt, 1);
    chk("p_ifgnt", bus.if_gnt, 0);
    tick(); #1;
    chk("p_dsize", bus.mem_dsize, 4'b0011);
    chk("p_addr", bus.mem_addr, 32'h40);
    tick();
    bus.ls_req = 0; bus.mem_rdata = 32'h55667788;
    #1;
    chk("p_lsv", bus.ls_valid, 1);
    chk("p_lsd", bus.ls_rdata, 32'h11223344);
    chk("p_ifgnt2", bus.if_gnt, 1);
    tick(); #1;
    chk("p_faddr", bus.mem_addr, 32'h20);
    chk("p_fdsize", bus.mem_dsize, 4'hF);
    tick();
    bus.if_req = 0;
    #1;
    chk("p_ifv", bus.if_valid, 1);
    chk("p_ifd", bus.if_rdata, 32'h55667788);
    chk("p_lshold", bus.ls_rdata, 32'h11223344);
`endif
    // reset during WRITE
    tick();
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_size = 2; bus.ls_addr = 32'h200; bus.ls_wdata = 32'h12345678;
    #1;
    chk("r_gnt", bus.ls_gnt, 1);
    tick(); #1;
    chk("r_wr", bus.mem_rwr, 0);
    chk("r_dsize", bus.mem_dsize, 4'hF);
    rts = 0;
    tick();
    bus.ls_req = 0;
    #1;
    chk("r_rwr", bus.mem_rwr, 1);
    chk("r_oe", bus.mem_wdata_oe, 0);
    chk("r_busy", busy, 0);
    chk("r_dsize0", bus.mem_dsize, 0);
    rts = 1;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      chk($sformatf("r_nolsv%0d", c), bus.ls_valid, 0);
      chk($sformatf("r_idle%0d", c), busy, 0);
    end
    // ls request withdrawn while fetch owns the bus
    tick();
    bus.if_req = 1; bus.if_addr = 32'h30; bus.mem_rdata = 32'hCAFEF00D;
    #1;
    chk("w_ifgnt", bus.if_gnt, 1);
    tick();
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_size = 2; bus.ls_addr = 32'h80;
    #1;
    chk("w_lsgnt", bus.ls_gnt, 0);
    tick();
    bus.ls_req = 0; bus.if_req = 0;
    #1;
    chk("w_ifv", bus.if_valid, 1);
    chk("w_ifd", bus.if_rdata, 32'hCAFEF00D);
    chk("w_lsgnt2", bus.ls_gnt, 0);
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      chk($sformatf("w_busy%0d", c), busy, 0);
      chk($sformatf("w_dsize%0d", c), bus.mem_dsize, 0);
      chk($sformatf("w_rwr%0d", c), bus.mem_rwr, 1);
      chk($sformatf("w_oe%0d", c), bus.mem_wdata_oe, 0);
      chk($sformatf("w_lsv%0d", c), bus.ls_valid, 0);
    end
`ifdef MEM_ARB_RR_EN
    // round-robin order after reset with both requesting continuously
    rts = 0;
    tick();
    rts = 1;
    bus.if_req = 1; bus.if_addr = 32'h4; bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h8;
    begin
      int n = 0;
      logic [3:0] order = 4'b0;
      for (int c = 0; c < 40 && n < 4; c++) begin
        tick();
        if (bus.ls_gnt || bus.if_gnt) begin
          order[n] = bus.ls_gnt;
          n++;
        end
      end
      chk("rr_count", n, 4);
      chk("rr_order", order, 4'b0101);
    end
    bus.if_req = 0; bus.ls_req = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
